// File: rtl/triad_arbiter_pkg.sv
// Shared widths and FSM encoding for the triad arbiter and its round-robin picker.
package triad_arbiter_pkg;

    localparam int SENSOR_W = 102;
    localparam int TS_W     = 24;
    localparam int DROP_W   = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_OUTPUT = 1'b1
    } state_t;

endpackage

// File: rtl/triad_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_grant
);

    always_comb begin
        grant     = '0;
        any_grant = |req;
        // Scan from the farthest offset back to ptr so the nearest request wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                grant = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/triad_arbiter.sv
// Arbitrates N_TRIADS single-entry sensor slots onto one valid/ready output channel, round-robin.
module triad_arbiter
    import triad_arbiter_pkg::*;
#(
    parameter int N_TRIADS = 4,
    parameter int ID_W     = 3
) (
    input  logic                           clk_72MHz,
    input  logic                           reset,
    input  logic [TS_W-1:0]                sys_ts,
    input  logic [N_TRIADS-1:0]            data_avl,
    input  logic [SENSOR_W*N_TRIADS-1:0]   sensor_iterations,
    output logic [N_TRIADS-1:0]            reset_parser,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SENSOR_W-1:0]            out_data,
    output logic [TS_W-1:0]                out_ts,
    output logic [ID_W-1:0]                out_id,
    output logic [DROP_W*N_TRIADS-1:0]     drop_cnt
);

    logic [SENSOR_W-1:0] slot_data [N_TRIADS];
    logic [TS_W-1:0]     slot_ts   [N_TRIADS];
    logic [N_TRIADS-1:0] pending;
    logic [N_TRIADS-1:0] reloaded;
    logic [DROP_W-1:0]   drop      [N_TRIADS];

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant;
    logic                any_grant;
    logic [SENSOR_W-1:0] sel_data;
    logic [TS_W-1:0]     sel_ts;
    logic [N_TRIADS-1:0] hit;

    state_t state, state_nxt;
    logic   load_out;
    logic   accept;

    rr_priority_picker #(
        .N_REQ (N_TRIADS),
        .ID_W  (ID_W)
    ) u_picker (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_grant) begin
                    load_out  = 1'b1;
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        sel_ts   = '0;
        hit      = '0;
        for (int i = 0; i < N_TRIADS; i++) begin
            if (grant == ID_W'(i)) begin
                sel_data = slot_data[i];
                sel_ts   = slot_ts[i];
            end
            hit[i] = accept && (out_id == ID_W'(i));
        end
    end

    // NOTE: slot payload storage has no reset; pending gates every read of it.
    always_ff @(posedge clk_72MHz) begin
        for (int i = 0; i < N_TRIADS; i++) begin
            if (data_avl[i]) begin
                slot_data[i] <= sensor_iterations[SENSOR_W*i +: SENSOR_W];
                slot_ts[i]   <= sys_ts;
            end
        end
    end

    // reloaded marks a slot refilled since its last copy to the output, so that
    // acceptance of the older copy leaves the newer payload pending for delivery.
    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            reloaded <= '0;
            for (int i = 0; i < N_TRIADS; i++) drop[i] <= '0;
        end else begin
            for (int i = 0; i < N_TRIADS; i++) begin
                if (data_avl[i]) begin
                    pending[i]  <= 1'b1;
                    reloaded[i] <= 1'b1;
                    if (pending[i] && !hit[i] && drop[i] != DROP_MAX) begin
                        drop[i] <= drop[i] + DROP_W'(1);
                    end
                end else begin
                    if (hit[i]) pending[i] <= reloaded[i];
                    if (load_out && grant == ID_W'(i)) reloaded[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ts       <= '0;
            out_id       <= '0;
            reset_parser <= '0;
            rr_ptr       <= '0;
        end else begin
            reset_parser <= hit;
            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ts    <= sel_ts;
                out_id    <= grant;
            end
            if (accept) begin
                out_valid <= 1'b0;
                rr_ptr    <= (out_id == ID_W'(N_TRIADS - 1)) ? '0 : out_id + ID_W'(1);
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N_TRIADS; i++) drop_cnt[DROP_W*i +: DROP_W] = drop[i];
    end

endmodule
